// File: rtl/window_gen_4x4.sv
// Sliding 4x4 pixel window behind the 4-row line buffer, with frame position tracking.
// Define WIN_OUT_REG_EN to add one more output register stage, which gives 2-cycle latency.
module window_gen_4x4 #(
    parameter int INPUT_SIZE   = 8,
    parameter int LINE_WIDTH   = 114,
    parameter int FRAME_HEIGHT = 114,
    parameter int CNT_W        = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sof,
    input  logic                    in_valid,
    input  logic [INPUT_SIZE-1:0]   in1,
    input  logic [INPUT_SIZE-1:0]   in2,
    input  logic [INPUT_SIZE-1:0]   in3,
    input  logic [INPUT_SIZE-1:0]   in4,
    output logic [16*INPUT_SIZE-1:0] win,
    output logic                    win_valid,
    output logic [CNT_W-1:0]        win_x,
    output logic [CNT_W-1:0]        win_y,
    output logic                    line_done,
    output logic                    frame_done
);

    logic [INPUT_SIZE-1:0]   w_reg [4][4];
    logic [INPUT_SIZE-1:0]   in_col [4];
    logic [16*INPUT_SIZE-1:0] win_s1;

    logic [CNT_W-1:0] col_cnt_reg, row_cnt_reg;
    logic [CNT_W-1:0] col_eff, row_eff;
    logic             col_wrap, row_wrap, pos_ok;

    logic             valid_s1_reg, line_done_s1_reg, frame_done_s1_reg;
    logic [CNT_W-1:0] x_s1_reg, y_s1_reg;

    assign in_col[0] = in1;
    assign in_col[1] = in2;
    assign in_col[2] = in3;
    assign in_col[3] = in4;

    // sof restarts the frame on this very column, so it is counted as (0,0)
    assign col_eff  = sof ? '0 : col_cnt_reg;
    assign row_eff  = sof ? '0 : row_cnt_reg;
    assign col_wrap = (col_eff == CNT_W'(LINE_WIDTH - 1));
    assign row_wrap = (row_eff == CNT_W'(FRAME_HEIGHT - 1));
    assign pos_ok   = (col_eff >= CNT_W'(3)) && (row_eff >= CNT_W'(3));

    genvar gi, gc;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_row
            for (gc = 0; gc < 4; gc++) begin : g_col
                logic [INPUT_SIZE-1:0] shift_in;
                if (gc == 3) begin : g_newest
                    assign shift_in = in_col[gi];
                end else begin : g_older
                    assign shift_in = sof ? '0 : w_reg[gi][gc+1];
                end

                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        w_reg[gi][gc] <= '0;
                    end else if (in_valid) begin
                        w_reg[gi][gc] <= shift_in;
                    end else if (sof) begin
                        w_reg[gi][gc] <= '0;
                    end
                end

                assign win_s1[(16 - (gi*4 + gc))*INPUT_SIZE - 1 -: INPUT_SIZE] = w_reg[gi][gc];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_cnt_reg <= '0;
            row_cnt_reg <= '0;
        end else if (in_valid) begin
            col_cnt_reg <= col_wrap ? '0 : col_eff + CNT_W'(1);
            if (col_wrap) begin
                row_cnt_reg <= row_wrap ? '0 : row_eff + CNT_W'(1);
            end else begin
                row_cnt_reg <= row_eff;
            end
        end else if (sof) begin
            col_cnt_reg <= '0;
            row_cnt_reg <= '0;
        end
    end

    // Columns 0..2 of each line still hold the previous line's tail, hence pos_ok gating
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_s1_reg      <= 1'b0;
            line_done_s1_reg  <= 1'b0;
            frame_done_s1_reg <= 1'b0;
            x_s1_reg          <= '0;
            y_s1_reg          <= '0;
        end else begin
            valid_s1_reg      <= in_valid && pos_ok;
            line_done_s1_reg  <= in_valid && col_wrap;
            frame_done_s1_reg <= in_valid && col_wrap && row_wrap;
            x_s1_reg          <= (in_valid && pos_ok) ? col_eff - CNT_W'(3) : '0;
            y_s1_reg          <= (in_valid && pos_ok) ? row_eff - CNT_W'(3) : '0;
        end
    end

`ifdef WIN_OUT_REG_EN
    logic [16*INPUT_SIZE-1:0] win_s2_reg;
    logic                    valid_s2_reg, line_done_s2_reg, frame_done_s2_reg;
    logic [CNT_W-1:0]        x_s2_reg, y_s2_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_s2_reg        <= '0;
            valid_s2_reg      <= 1'b0;
            line_done_s2_reg  <= 1'b0;
            frame_done_s2_reg <= 1'b0;
            x_s2_reg          <= '0;
            y_s2_reg          <= '0;
        end else begin
            win_s2_reg        <= win_s1;
            valid_s2_reg      <= valid_s1_reg;
            line_done_s2_reg  <= line_done_s1_reg;
            frame_done_s2_reg <= frame_done_s1_reg;
            x_s2_reg          <= x_s1_reg;
            y_s2_reg          <= y_s1_reg;
        end
    end

    assign win        = win_s2_reg;
    assign win_valid  = valid_s2_reg;
    assign win_x      = x_s2_reg;
    assign win_y      = y_s2_reg;
    assign line_done  = line_done_s2_reg;
    assign frame_done = frame_done_s2_reg;
`else
    assign win        = win_s1;
    assign win_valid  = valid_s1_reg;
    assign win_x      = x_s1_reg;
    assign win_y      = y_s1_reg;
    assign line_done  = line_done_s1_reg;
    assign frame_done = frame_done_s1_reg;
`endif

endmodule

// File: doc/window_gen_4x4.md
Name: window_gen_4x4

Overview:
- Stage directly downstream of the 4-row line buffer.
- Each valid cycle it accepts one 4-pixel column: four vertically adjacent pixels, oldest row first.
- Builds a sliding 4x4 pixel window in shift registers and tracks column/row position in the frame.
- Presents the full 16-pixel window, with a valid strobe and top-left coordinates, to the LUT index/lookup stage.

Parameters:
- INPUT_SIZE, 8, pixel width in bits.
- LINE_WIDTH, 114, pixels per line. Must match the line buffer.
- FRAME_HEIGHT, 114, lines per frame.
- CNT_W, 9, width of the column/row counters and coordinate outputs. Requires 2^CNT_W > max(LINE_WIDTH, FRAME_HEIGHT).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- sof  in  1  start-of-frame pulse. Synchronous restart of counters and window.
- in_valid  in  1  in1..in4 carry a valid column this cycle.
- in1  in  INPUT_SIZE  oldest row (window row 0).
- in2  in  INPUT_SIZE  window row 1.
- in3  in  INPUT_SIZE  window row 2.
- in4  in  INPUT_SIZE  newest row (window row 3).
- win  out  16*INPUT_SIZE  window, packed row-major. Bits [16*INPUT_SIZE-1 -: INPUT_SIZE] = row0/col0 (top-left); bits [INPUT_SIZE-1:0] = row3/col3 (bottom-right).
- win_valid  out  1  win, win_x, win_y are valid this cycle.
- win_x  out  CNT_W  column index of window col0.
- win_y  out  CNT_W  line index of window row0.
- line_done  out  1  one-cycle pulse after the last column of a line is accepted.
- frame_done  out  1  one-cycle pulse after the last column of the last line is accepted.

Behaviour:
- Reset (rst=0, asynchronous): all window registers 0; col_cnt, row_cnt 0; win, win_x, win_y 0; win_valid, line_done, frame_done 0.
- Window storage: w[r][c], r=0..3, c=0..3; c=3 is the newest column.
  - On in_valid=1: w[r][c] <= w[r][c+1] for c=0..2, and w[r][3] <= in(r+1).
  - On in_valid=0: all window registers hold; win_valid=0, line_done=0, frame_done=0 (stall, no bubble state).
- Counters:
  - col_cnt increments on each accepted column and wraps LINE_WIDTH-1 -> 0.
  - On that wrap, row_cnt increments and wraps FRAME_HEIGHT-1 -> 0.
- Valid rule: for an accepted column with pre-increment counts (c, r), the next cycle has:
  - win_valid = (c >= 3) && (r >= 3);
  - win_x = c-3; win_y = r-3;
  - win = shifted window contents.
  - Latency in_valid -> win_valid: 1 cycle.
- Line wrap: columns from the previous line remain in w[][0..2] after wrap. They are never exposed, because win_valid is suppressed for c=0..2 of each line. No clearing at wrap.
- line_done = 1 in the cycle after accepting c=LINE_WIDTH-1.
- frame_done = 1 additionally when r=FRAME_HEIGHT-1 on that same column.
- sof:
  - sof=1 with in_valid=0: col_cnt, row_cnt and window registers cleared; outputs deasserted next cycle.
  - sof=1 with in_valid=1: counters are cleared and the column is accepted as (c=0, r=0). Window is cleared, then loaded with the column at col3; win_valid=0 next cycle.
- Mid-frame reset: immediate return to reset values. Accumulated position is lost; the next frame must begin with sof or from counts 0/0.
- Arithmetic: counters unsigned CNT_W bits. Subtraction for win_x/win_y is only evaluated when c >= 3 and r >= 3, so no underflow is ever output.

Optional Feature:
- Macro: WIN_OUT_REG_EN.
- Defined: an extra output register stage on win, win_valid, win_x, win_y, line_done, frame_done.
  - Latency becomes 2 cycles.
  - The stage advances every cycle regardless of in_valid; outputs of a stalled cycle are 0-valid.
  - Reset also clears this stage.
- Undefined: latency 1 as specified above.

Test Plan:
- Config LINE_WIDTH=8, FRAME_HEIGHT=6. After reset, feed 48 columns where pixel = {row[3:0], col[3:0]}.
  - Expect exactly 5*3 = 15 win_valid pulses.
  - First pulse has win_x=0, win_y=0, top-left=8'h00, bottom-right=8'h33.
  - Expect frame_done exactly once, after column 48.
- Same stream with in_valid deasserted every other cycle -> identical window sequence and count; win_valid never high in a stall cycle.
- Line wrap: at row 4 (r=4), columns 0..2 -> win_valid=0. Column 3 -> win_x=0, win_y=1, win col0 = 8'h10..8'h40 row values, with no previous-line pixels.
- sof asserted together with in_valid mid-line (r=2, c=5) -> next accepted column counts as c=1. No win_valid until c=3 on r=3 of the new frame.
- Assert rst low for 1 cycle mid-frame (asynchronous, between clock edges) -> win_valid, line_done, frame_done, win immediately 0. Restart reproduces the first test.
- With WIN_OUT_REG_EN defined, rerun the first test -> same 15 windows and values, each one cycle later than without the macro.
